// File: rtl/flash_cmd_pkg.sv
// Intel-style flash command bytes, status register bit positions and the
// sequencer state encoding shared by the flash access blocks.
package flash_cmd_pkg;

    localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;
    localparam logic [7:0] CMD_PROGRAM    = 8'h40;
    localparam logic [7:0] CMD_CLR_STATUS = 8'h50;

    localparam int SR_READY    = 7;
    localparam int SR_PROG_ERR = 4;
    localparam int SR_VPP_ERR  = 3;
    localparam int SR_LOCK     = 1;

    // Each even code below IDLE issues one bridge op; code+1 is its wait state.
    localparam logic [3:0] ST_INIT         = 4'd0;
    localparam logic [3:0] ST_INIT_WAIT    = 4'd1;
    localparam logic [3:0] ST_RD           = 4'd2;
    localparam logic [3:0] ST_RD_WAIT      = 4'd3;
    localparam logic [3:0] ST_PG_CMD       = 4'd4;
    localparam logic [3:0] ST_PG_CMD_WAIT  = 4'd5;
    localparam logic [3:0] ST_PG_DATA      = 4'd6;
    localparam logic [3:0] ST_PG_DATA_WAIT = 4'd7;
    localparam logic [3:0] ST_POLL         = 4'd8;
    localparam logic [3:0] ST_POLL_WAIT    = 4'd9;
    localparam logic [3:0] ST_CLR          = 4'd10;
    localparam logic [3:0] ST_CLR_WAIT     = 4'd11;
    localparam logic [3:0] ST_RESTORE      = 4'd12;
    localparam logic [3:0] ST_RESTORE_WAIT = 4'd13;
    localparam logic [3:0] ST_IDLE         = 4'd14;
    localparam logic [3:0] ST_COMPLETE     = 4'd15;

    typedef enum logic [3:0] {
        S_INIT         = ST_INIT,
        S_INIT_WAIT    = ST_INIT_WAIT,
        S_RD           = ST_RD,
        S_RD_WAIT      = ST_RD_WAIT,
        S_PG_CMD       = ST_PG_CMD,
        S_PG_CMD_WAIT  = ST_PG_CMD_WAIT,
        S_PG_DATA      = ST_PG_DATA,
        S_PG_DATA_WAIT = ST_PG_DATA_WAIT,
        S_POLL         = ST_POLL,
        S_POLL_WAIT    = ST_POLL_WAIT,
        S_CLR          = ST_CLR,
        S_CLR_WAIT     = ST_CLR_WAIT,
        S_RESTORE      = ST_RESTORE,
        S_RESTORE_WAIT = ST_RESTORE_WAIT,
        S_IDLE         = ST_IDLE,
        S_COMPLETE     = ST_COMPLETE
    } state_e;

    function automatic logic status_err(input logic [7:0] sr);
        return sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK];
    endfunction

endpackage

// File: rtl/flash_rr_arbiter.sv
// Two-client round-robin arbiter: on a tie the client not granted last time wins.
module flash_rr_arbiter (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    // Reset to client 1 so that client 0 wins the first tie.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            r_last_grant <= 1'b1;
        end else if (i_grant_en && (|i_req)) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/flash_access_sequencer.sv
// Arbitrates two clients onto the flash bridge and expands program requests
// into the program / status-poll / clear / read-array command sequence.
module flash_access_sequencer
    import flash_cmd_pkg::*;
#(
    parameter int unsigned POLL_MAX  = 255,
    parameter logic [7:0]  INIT_ADDR = 8'h00
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_write,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req0_wdata,
    input  logic [7:0] req1_wdata,
    output logic [1:0] req_ready,
    output logic [1:0] req_done,
    output logic       req_err,
    output logic [7:0] rdata,
    output logic [7:0] fb_addr,
    output logic [7:0] fb_wdata,
    input  logic [7:0] fb_rdata,
    output logic       fb_dir_rw,
    output logic       fb_start,
    input  logic       fb_done,
    output logic       busy
);

    localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

    state_e     r_state;
    logic [1:0] r_gnt;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_status;
    logic [7:0] r_poll_cnt;
    logic       r_err;

    logic [1:0] w_grant;
    logic       w_grant_en;
    logic       w_grant_write;
    logic       w_issue;
    logic       w_op_read;
    logic [7:0] w_op_data;
    logic [7:0] w_cnt_inc;

    assign w_grant_en    = (r_state == S_IDLE) && (|req_valid);
    assign w_grant_write = |(req_write & w_grant);

    flash_rr_arbiter u_arb (
        .CLK_50MHZ  (CLK_50MHZ),
        .RST        (RST),
        .i_req      (req_valid),
        .i_grant_en (w_grant_en),
        .o_grant    (w_grant)
    );

    assign w_issue   = ~r_state[0] && (r_state != S_IDLE);
    assign w_cnt_inc = (r_poll_cnt >= POLL_LIMIT) ? POLL_LIMIT : r_poll_cnt + 8'd1;

    always_comb begin
        w_op_read = 1'b0;
        w_op_data = 8'h00;
        case (r_state)
            S_INIT, S_RESTORE: w_op_data = CMD_READ_ARRAY;
            S_PG_CMD:          w_op_data = CMD_PROGRAM;
            S_PG_DATA:         w_op_data = r_wdata;
            S_CLR:             w_op_data = CMD_CLR_STATUS;
            S_RD, S_POLL:      w_op_read = 1'b1;
            default:           w_op_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            r_state    <= S_INIT;
            fb_start   <= 1'b0;
            fb_dir_rw  <= 1'b1;
            fb_addr    <= 8'h00;
            fb_wdata   <= 8'h00;
            req_ready  <= 2'b00;
            req_done   <= 2'b00;
            req_err    <= 1'b0;
            rdata      <= 8'h00;
            busy       <= 1'b1;
            r_poll_cnt <= 8'h00;
            r_gnt      <= 2'b00;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_status   <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            fb_start  <= 1'b0;
            req_ready <= 2'b00;
            req_done  <= 2'b00;
            if (w_issue) begin
                // Op fields stay untouched in the wait state, so they are stable until fb_done.
                fb_start  <= 1'b1;
                fb_addr   <= (r_state == S_INIT) ? INIT_ADDR : r_addr;
                fb_wdata  <= w_op_data;
                fb_dir_rw <= w_op_read;
                r_state   <= state_e'(r_state | 4'd1);
            end else begin
                case (r_state)
                    S_INIT_WAIT: if (fb_done) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    S_IDLE: if (w_grant_en) begin
                        req_ready <= w_grant;
                        r_gnt     <= w_grant;
                        r_addr    <= w_grant[1] ? req1_addr : req0_addr;
                        r_wdata   <= w_grant[1] ? req1_wdata : req0_wdata;
                        busy      <= 1'b1;
                        r_state   <= w_grant_write ? S_PG_CMD : S_RD;
                    end
                    S_RD_WAIT: if (fb_done) begin
                        rdata    <= fb_rdata;
                        req_err  <= 1'b0;
                        req_done <= r_gnt;
                        r_state  <= S_COMPLETE;
                    end
                    S_PG_CMD_WAIT: if (fb_done) begin
                        r_state <= S_PG_DATA;
                    end
                    S_PG_DATA_WAIT: if (fb_done) begin
                        r_poll_cnt <= 8'h00;
                        r_state    <= S_POLL;
                    end
                    S_POLL_WAIT: if (fb_done) begin
                        r_poll_cnt <= w_cnt_inc;
                        if (fb_rdata[SR_READY]) begin
                            r_status <= fb_rdata;
                            r_err    <= status_err(fb_rdata);
                            r_state  <= status_err(fb_rdata) ? S_CLR : S_RESTORE;
                        end else if (w_cnt_inc == POLL_LIMIT) begin
                            r_status <= fb_rdata;
                            r_err    <= 1'b1;
                            r_state  <= S_CLR;
                        end else begin
                            r_state <= S_POLL;
                        end
                    end
                    S_CLR_WAIT: if (fb_done) begin
                        r_state <= S_RESTORE;
                    end
                    S_RESTORE_WAIT: if (fb_done) begin
                        rdata    <= r_status;
                        req_err  <= r_err;
                        req_done <= r_gnt;
                        r_state  <= S_COMPLETE;
                    end
                    S_COMPLETE: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    default: r_state <= S_INIT;
                endcase
            end
        end
    end

endmodule
